// File: rtl/splitter_pkg.sv
// Shared types and constants for the splitter S00_AXI register bank.
package splitter_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int unsigned REG_IDX_CTRL   = 0;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Merge write data into an existing word; only strobed bytes change.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_byte_reg.sv
// 32-bit register with per-byte write enables and asynchronous active-low clear.
module axil_byte_reg
  import splitter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // Storage: byte-merged update on write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 32'h0000_0000;
    end else if (we) begin
      q <= apply_wstrb(q, wdata, strb);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/splitter_axil_regs.sv
// AXI4-Lite slave register bank: NUM_REGS words, independent read and write paths,
// per-register write strobe pulsed in the cycle after each accepted write.
module splitter_axil_regs
  import splitter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  reg_wr_stb
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_e                     wr_state_r;
  rd_state_e                     rd_state_r;
  logic                          awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]                    bresp_r, rresp_r;
  logic                          aw_held_r, w_held_r;
  logic [IDX_W-1:0]              aw_idx_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_r, rdata_r;
  logic [STB_W-1:0]              wstrb_r;
  logic [NUM_REGS-1:0]           reg_wr_stb_r;

  logic                          aw_hs_s, w_hs_s, wr_fire_s, ar_hs_s;
  logic [IDX_W-1:0]              wr_idx_s, rd_idx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_s;
  logic [STB_W-1:0]              wr_strb_s;
  logic [NUM_REGS-1:0]           wr_sel_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_q_s [NUM_REGS];
  logic                          unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write fires on the edge where address and data are both available, held or arriving.
  always_comb begin
    aw_hs_s   = S_AXI_AWVALID & awready_r;
    w_hs_s    = S_AXI_WVALID & wready_r;
    ar_hs_s   = S_AXI_ARVALID & arready_r;
    wr_fire_s = (wr_state_r == W_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
    wr_idx_s  = aw_held_r ? aw_idx_r : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    wr_data_s = w_held_r ? wdata_r : S_AXI_WDATA;
    wr_strb_s = w_held_r ? wstrb_r : S_AXI_WSTRB;
    wr_sel_s  = {{(NUM_REGS-1){1'b0}}, 1'b1} << wr_idx_s;
    rd_idx_s  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    axil_byte_reg u_reg (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .we    (wr_fire_s & wr_sel_s[g]),
      .strb  (wr_strb_s),
      .wdata (wr_data_s),
      .q     (reg_q_s[g])
    );
    assign reg_out[C_S_AXI_DATA_WIDTH*g +: C_S_AXI_DATA_WIDTH] = reg_q_s[g];
  end

  // Write channel FSM: collects AW and W in any order, then holds B until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_r   <= W_IDLE;
      awready_r    <= 1'b0;
      wready_r     <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= AXI_RESP_OKAY;
      aw_held_r    <= 1'b0;
      w_held_r     <= 1'b0;
      aw_idx_r     <= '0;
      wdata_r      <= '0;
      wstrb_r      <= '0;
      reg_wr_stb_r <= '0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (wr_fire_s) begin
            wr_state_r   <= W_RESP;
            bvalid_r     <= 1'b1;
            bresp_r      <= AXI_RESP_OKAY;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            aw_held_r    <= 1'b0;
            w_held_r     <= 1'b0;
            reg_wr_stb_r <= wr_sel_s;
          end else begin
            reg_wr_stb_r <= '0;
            if (aw_hs_s) begin
              aw_held_r <= 1'b1;
              aw_idx_r  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
              awready_r <= 1'b0;
            end else begin
              awready_r <= ~aw_held_r;
            end
            if (w_hs_s) begin
              w_held_r <= 1'b1;
              wdata_r  <= S_AXI_WDATA;
              wstrb_r  <= S_AXI_WSTRB;
              wready_r <= 1'b0;
            end else begin
              wready_r <= ~w_held_r;
            end
          end
        end
        W_RESP: begin
          reg_wr_stb_r <= '0;
          if (S_AXI_BREADY) begin
            wr_state_r <= W_IDLE;
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end else begin
            bvalid_r <= 1'b1;
          end
        end
        default: begin
          wr_state_r   <= W_IDLE;
          bvalid_r     <= 1'b0;
          awready_r    <= 1'b0;
          wready_r     <= 1'b0;
          aw_held_r    <= 1'b0;
          w_held_r     <= 1'b0;
          reg_wr_stb_r <= '0;
        end
      endcase
    end
  end

  // Read channel FSM: captures the addressed word (pre-write value on a same-edge write).
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= '0;
      rresp_r    <= AXI_RESP_OKAY;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rd_state_r <= R_DATA;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rdata_r    <= reg_q_s[rd_idx_s];
            rresp_r    <= AXI_RESP_OKAY;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rd_state_r <= R_IDLE;
            rvalid_r   <= 1'b0;
            arready_r  <= 1'b1;
          end else begin
            rvalid_r <= 1'b1;
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
          rvalid_r   <= 1'b0;
          arready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign reg_wr_stb    = reg_wr_stb_r;

endmodule

// File: tb/tb_splitter_axil_regs.sv
// Self-checking bench for splitter_axil_regs: directed cases plus random traffic vs. a word-array model.
module tb_splitter_axil_regs;

  localparam int AW = 4;
  localparam int NR = 4;

  logic          tb_ACLK = 1'b0;
  logic          tb_ARESETN = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_AWPROT = 3'b000, S_AXI_ARPROT = 3'b000;
  logic          S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
  logic          S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0]   S_AXI_RDATA;
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0] reg_wr_stb;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model [NR];
  int          stb_cnt [NR] = '{default: 0};

  always #5 tb_ACLK = ~tb_ACLK;

  splitter_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(tb_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
  );

  // Count strobe pulses per register, one per high cycle.
  always @(posedge tb_ACLK) begin
    for (int i = 0; i < NR; i++) begin
      if (reg_wr_stb[i]) stb_cnt[i] <= stb_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int stb_total();
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += stb_cnt[i];
    return s;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc, idx, stb_before, tot_before;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [NR-1:0] exp_sel;
    idx = int'(addr[AW-1:2]);
    stb_before = stb_cnt[idx];
    tot_before = stb_total();
    cyc = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && cyc < 64) begin
      @(negedge tb_ACLK);
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_AWADDR  = addr;
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      if (aw_done != w_done) begin
        check("wr_half_no_bvalid", 32'(S_AXI_BVALID), 32'(0));
        check("wr_half_ready_drop", 32'(aw_done ? S_AXI_AWREADY : S_AXI_WREADY), 32'(0));
      end
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge tb_ACLK);
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
      cyc++;
    end
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_accepted", 32'({aw_done, w_done}), 32'(2'b11));
    if (!(aw_done && w_done)) return;
    model[idx] = merge(model[idx], data, strb);
    exp_sel = '0;
    exp_sel[idx] = 1'b1;
    check("bvalid", 32'(S_AXI_BVALID), 32'(1));
    check("bresp", 32'(S_AXI_BRESP), 32'(0));
    check("wr_resp_readies", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'(0));
    check("reg_out_after_wr", reg_out[32*idx +: 32], model[idx]);
    check("reg_wr_stb", 32'(reg_wr_stb), 32'(exp_sel));
    repeat (b_dly) begin
      @(negedge tb_ACLK);
      check("b_hold_flags", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'(3'b100));
    end
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", 32'(S_AXI_BVALID), 32'(0));
    check("stb_count_reg", 32'(stb_cnt[idx] - stb_before), 32'(1));
    check("stb_count_total", 32'(stb_total() - tot_before), 32'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int r_dly, output logic [31:0] data);
    int cyc;
    bit done, hs;
    cyc = 0; done = 1'b0;
    data = 32'h0;
    while (!done && cyc < 64) begin
      @(negedge tb_ACLK);
      S_AXI_ARVALID = 1'b1;
      S_AXI_ARADDR  = addr;
      hs = S_AXI_ARREADY;
      @(posedge tb_ACLK);
      if (hs) done = 1'b1;
      cyc++;
    end
    @(negedge tb_ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rd_accepted", 32'(done), 32'(1));
    if (!done) return;
    check("rvalid", 32'(S_AXI_RVALID), 32'(1));
    check("rresp", 32'(S_AXI_RRESP), 32'(0));
    data = S_AXI_RDATA;
    repeat (r_dly) begin
      @(negedge tb_ACLK);
      check("rdata_stable", S_AXI_RDATA, data);
      check("r_hold_flags", 32'({S_AXI_RVALID, S_AXI_ARREADY}), 32'(2'b10));
    end
    S_AXI_RREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_cleared", 32'(S_AXI_RVALID), 32'(0));
  endtask

  initial begin
    logic [31:0] rd, old_c;
    logic [31:0] init_vals [NR];
    logic [AW-1:0] a;
    init_vals = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge tb_ACLK);
    check("rst_reg_out", reg_out[31:0] | reg_out[63:32] | reg_out[95:64] | reg_out[127:96], 32'h0);
    check("rst_flags", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}), 32'(0));
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_resp_stb", 32'({S_AXI_BRESP, S_AXI_RRESP, reg_wr_stb}), 32'(0));
    tb_ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);

    // Full-word writes to every register, then readback
    for (int i = 0; i < NR; i++) do_write(AW'(4 * i), init_vals[i], 4'hF, 0, 0, 0);
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(4 * i), 0, rd);
      check("init_readback", rd, init_vals[i]);
    end

    // W ahead of AW, then AW ahead of W
    do_write(4'h4, 32'h5555AAAA, 4'hF, 3, 0, 0);
    do_write(4'h4, 32'h0F0F1234, 4'hF, 0, 3, 0);
    do_read(4'h4, 0, rd);
    check("order_readback", rd, 32'h0F0F1234);

    // Byte-strobed write over reg2
    do_write(4'h8, 32'h12345678, 4'h5, 0, 0, 0);
    do_read(4'h8, 0, rd);
    check("strb_readback", rd, 32'hDE340078);

    // Back-pressure on B and R
    do_write(4'h0, 32'hCAFEF00D, 4'hF, 1, 0, 5);
    do_read(4'h0, 5, rd);
    check("bp_readback", rd, model[0]);

    // Strobe-less write: no data change, still a response and a pulse
    do_write(4'h1, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    do_read(4'h2, 0, rd);
    check("zero_strb_readback", rd, 32'hCAFEF00D);

    // Same-edge read and write of reg3: read returns the old value
    old_c = model[3];
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'hC;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    check("same_edge_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'(3'b111));
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model[3] = 32'h0;
    check("same_edge_rdata", S_AXI_RDATA, old_c);
    check("same_edge_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'(2'b11));
    check("same_edge_reg_out", reg_out[127:96], model[3]);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    do_read(4'hC, 0, rd);
    check("same_edge_next_read", rd, model[3]);

    // Reset while BVALID is pending
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("pre_reset_bvalid", 32'(S_AXI_BVALID), 32'(1));
    #2 tb_ARESETN = 1'b0;
    #1;
    check("reset_async_bvalid", 32'(S_AXI_BVALID), 32'(0));
    check("reset_async_reg1", reg_out[63:32], 32'h0);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(4 * i), 0, rd);
      check("post_reset_read", rd, model[i]);
    end
    do_write(4'h4, 32'h2468ACE0, 4'hF, 0, 0, 0);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2), rd);
        check("rand_read", rd, model[a[AW-1:2]]);
      end
    end
    for (int i = 0; i < NR; i++) check("final_reg_out", reg_out[32*i +: 32], model[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
